md5_pad: RTL and testbench
==========================

# md5_pad

MD5 message padder and block builder. Accepts a byte-granular message as a stream of 32-bit words and emits complete 512-bit MD5 blocks: message data, the 0x80 terminator, zero fill, and the 64-bit little-endian bit length. It sits upstream of the MD5 compression core and is the writer side of its block handshake. One message is in flight at a time; multi-block messages emit blocks in order, with the final block flagged.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  32  message word. Message byte k of the word is at bits [8k+7:8k].
- in_bytes  in  3  valid bytes in the last word, 0..4. Ignored unless in_last=1. Values 5..7 are treated as 4.
- in_last  in  1  this word ends the message.
- in_valid  in  1  word offered.
- in_ready  out  1  word accepted when in_valid & in_ready.
- blk  out  512  padded block. Word i is at blk[32i+31:32i].
- blk_last  out  1  this block carries the length (final block of the message).
- blk_valid  out  1  block offered.
- blk_ready  in  1  block consumed when blk_valid & blk_ready.

## Operation
- States: FILL, PAD, EMIT. Reset state is FILL.
- Registers: widx[3:0] (next word slot), pend80 (terminator still owed), len[63:0] (byte count), ret (state after EMIT), lastblk.
- FILL: in_ready=1. On each accepted word:
  - Write the word to slot widx.
  - If in_last=1, zero the invalid bytes. If in_bytes<4, also place 0x80 at byte in_bytes.
  - Add the byte count to len: 4 for a non-last word, in_bytes for the last word.
- Next state after an accepted word:
  - Non-last word, widx<15: widx++.
  - Non-last word, widx==15: go to EMIT with ret=FILL.
  - Last word: set pend80=(in_bytes>=4), then go to PAD, or to EMIT with ret=PAD if widx==15. widx++ (wraps to 0).
- PAD: in_ready=0. Acts once per cycle:
  - If widx==14 and pend80=0: write {len,3'b0} to words 14 (low 32 bits) and 15 (high 32 bits), set lastblk=1, go to EMIT.
  - Otherwise: write 0x00000080 if pend80, else 0, to slot widx. Clear pend80, then widx++. If widx was 15, go to EMIT with ret=PAD.
- EMIT: blk_valid=1, in_ready=0; blk and blk_last are held stable. On blk_ready: widx=0 and the block is cleared.
  - If lastblk: clear len and lastblk, go to FILL.
  - Otherwise go to ret.
- A second block is produced exactly when the 0x80 terminator lands in slot 14 or 15, or is still pending at a block boundary.
- Bit length is len×8 modulo 2^64; len wraps silently.

## Timing
- Reset values: blk=0, blk_valid=0, blk_last=0. in_ready=1 (FILL is decoded).
- blk, blk_valid and blk_last are registered. blk_valid rises in the cycle after the write that completes slot 15 or writes the length.
- Throughput: one word per cycle in FILL and in PAD. A block is held in EMIT for at least one cycle.
- Latency from the last accepted word at slot w (w≤13, in_bytes<4) to blk_valid: (14−(w+1))+1 cycles of PAD, plus 1 cycle.
- blk_ready asserted outside EMIT has no effect. in_valid is ignored outside FILL.
- Reset mid-message: all state, len and outputs return to reset values immediately. The partial message is discarded.

## Configuration
- MD5_PAD_BSWAP_EN defined: in_data is byte-reversed on entry. The first message byte is then taken from [31:24], giving big-endian word input for network-order sources.
- Not defined: in_data is used as-is, with byte 0 at [7:0].
- Padding, the length field and blk layout are identical in both builds.

## Test plan
- Empty message: in_last=1, in_bytes=0 -> one block. word0=0x00000080, words 1..15=0, blk_last=1.
- "abc": in_data=0x00636261, in_bytes=3, in_last=1 -> word0=0x80636261, word14=0x00000018, word15=0, blk_last=1.
- 56 bytes: 14 full words, the last with in_bytes=4 ->
  - Block 1: words 0..13 are data, word14=0x80, word15=0, blk_last=0.
  - Block 2: all zero except word14=0x000001C0; blk_last=1.
- 64 bytes: 16 full words ->
  - Block 1: data only, blk_last=0.
  - Block 2: word0=0x80, word14=0x00000200, blk_last=1.
- Backpressure: hold blk_ready=0 for 10 cycles during EMIT -> blk and blk_last are unchanged, and in_ready=0 throughout. Release -> FILL follows on the next cycle.
- Reset after 5 accepted words, then send "abc" -> blk_valid=0 and in_ready=1 during reset. The next block equals the "abc" result (word14=0x18).

Source files
------------

// File: rtl/md5_pad.sv
// MD5 padder: packs a 32-bit word stream into 512-bit blocks with terminator and length.
// Build option: define MD5_PAD_BSWAP_EN for big-endian (network order) word input.
module md5_pad (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] blk,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready
);

  typedef enum logic [1:0] {
    FILL,
    PAD,
    EMIT
  } state_t;

  state_t       state;
  state_t       state_d;
  state_t       ret;
  state_t       ret_d;
  logic [3:0]   widx;
  logic [3:0]   widx_d;
  logic         pend80;
  logic         pend80_d;
  logic         lastblk;
  logic         lastblk_d;
  logic [63:0]  len;
  logic [63:0]  len_d;
  logic [511:0] blk_d;
  logic [31:0]  din;
  logic [31:0]  lword;
  logic [2:0]   nb;
  logic [63:0]  bits;

`ifdef MD5_PAD_BSWAP_EN
  assign din = {in_data[7:0], in_data[15:8],
                in_data[23:16], in_data[31:24]};
`else
  assign din = in_data;
`endif

  assign nb = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign bits = {len[60:0], 3'b000};

  // Last word: drop invalid bytes, terminator goes right after the data
  always_comb begin
    lword = din;
    if (in_last) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) == nb)
          lword[8*k +: 8] = 8'h80;
        else if (3'(k) > nb)
          lword[8*k +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d   = state;
    ret_d     = ret;
    widx_d    = widx;
    pend80_d  = pend80;
    lastblk_d = lastblk;
    len_d     = len;
    blk_d     = blk;
    case (state)
      FILL: begin
        if (in_valid) begin
          blk_d[{widx, 5'd0} +: 32] = lword;
          widx_d = widx + 4'd1;
          if (in_last) begin
            len_d    = len + {61'd0, nb};
            pend80_d = (nb == 3'd4);
            if (widx == 4'd15) begin
              state_d = EMIT;
              ret_d   = PAD;
            end else begin
              state_d = PAD;
            end
          end else begin
            len_d = len + 64'd4;
            if (widx == 4'd15) begin
              state_d = EMIT;
              ret_d   = FILL;
            end
          end
        end
      end
      PAD: begin
        if (widx == 4'd14 && !pend80) begin
          blk_d[448 +: 32] = bits[31:0];
          blk_d[480 +: 32] = bits[63:32];
          lastblk_d = 1'b1;
          state_d   = EMIT;
        end else begin
          blk_d[{widx, 5'd0} +: 32] =
            {24'd0, pend80 ? 8'h80 : 8'h00};
          pend80_d = 1'b0;
          widx_d   = widx + 4'd1;
          if (widx == 4'd15) begin
            state_d = EMIT;
            ret_d   = PAD;
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          widx_d = 4'd0;
          blk_d  = '0;
          if (lastblk) begin
            len_d     = 64'd0;
            lastblk_d = 1'b0;
            state_d   = FILL;
          end else begin
            state_d = ret;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= FILL;
    else
      state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret     <= FILL;
      widx    <= 4'd0;
      pend80  <= 1'b0;
      lastblk <= 1'b0;
      len     <= 64'd0;
      blk     <= '0;
    end else begin
      ret     <= ret_d;
      widx    <= widx_d;
      pend80  <= pend80_d;
      lastblk <= lastblk_d;
      len     <= len_d;
      blk     <= blk_d;
    end
  end

  assign in_ready  = (state == FILL);
  assign blk_valid = (state == EMIT);
  assign blk_last  = lastblk;

endmodule

// File: tb/tb_md5_pad.sv
// Directed bench for md5_pad: empty, abc, 56/59/64-byte, clamp, backpressure, reset.
module tb_md5_pad;

  logic         clk;
  logic         rst;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] blk;
  logic         blk_last;
  logic         blk_valid;
  logic         blk_ready;

  int tests = 0;
  int fails = 0;

  logic [511:0] b;
  logic [511:0] e;
  logic         l;
  int           lat;

  md5_pad dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .blk       (blk),
    .blk_last  (blk_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dw(input int i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  task automatic send(input logic [31:0] d, input logic [2:0] n,
                      input logic last);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 100);
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_data  = d;
    in_bytes = n;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_blk(input int hold, output logic [511:0] ob,
                         output logic ol, output int olat);
    olat = 0;
    do begin
      @(negedge clk);
      olat++;
    end while (!blk_valid && olat < 300);
    chk("blk_valid_wait", 64'(blk_valid), 64'd1);
    ob = blk;
    ol = blk_last;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_blk", 64'(blk == ob), 64'd1);
      chk("hold_last", 64'(blk_last), 64'(ol));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(blk_valid), 64'd1);
    end
    @(negedge clk);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
  endtask

  task automatic check_blk(input string tag, input logic [511:0] gb,
                           input logic gl, input logic [511:0] eb,
                           input logic el);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_w%0d", tag, i),
          64'(gb[32*i +: 32]), 64'(eb[32*i +: 32]));
    chk($sformatf("%s_last", tag), 64'(gl), 64'(el));
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_bytes  = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(blk_valid), 64'd0);
    chk("rst_last", 64'(blk_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_blk_zero", 64'(blk == '0), 64'd1);
    rst = 1'b0;

    // empty message
    send(32'h0, 3'd0, 1'b1);
    get_blk(0, b, l, lat);
    chk("empty_lat", 64'(lat), 64'd15);
    e = '0;
    e[31:0] = 32'h00000080;
    check_blk("empty", b, l, e, 1'b1);

    // "abc" with 10 cycles of backpressure
    send(32'h00636261, 3'd3, 1'b1);
    get_blk(10, b, l, lat);
    chk("abc_lat", 64'(lat), 64'd15);
    e = '0;
    e[31:0]    = 32'h80636261;
    e[448 +: 32] = 32'h00000018;
    check_blk("abc", b, l, e, 1'b1);
    @(negedge clk);
    chk("abc_fill_after", 64'(in_ready), 64'd1);

    // 56 bytes
    for (int i = 0; i < 14; i++)
      send(dw(i), 3'd4, i == 13);
    get_blk(0, b, l, lat);
    e = '0;
    for (int i = 0; i < 14; i++) e[32*i +: 32] = dw(i);
    e[448 +: 32] = 32'h00000080;
    check_blk("m56_b1", b, l, e, 1'b0);
    get_blk(0, b, l, lat);
    e = '0;
    e[448 +: 32] = 32'h000001C0;
    check_blk("m56_b2", b, l, e, 1'b1);

    // 59 bytes: terminator lands in slot 14
    for (int i = 0; i < 15; i++)
      send(dw(i), (i == 14) ? 3'd3 : 3'd4, i == 14);
    get_blk(0, b, l, lat);
    e = '0;
    for (int i = 0; i < 14; i++) e[32*i +: 32] = dw(i);
    e[448 +: 32] = {8'h80, dw(14)[23:0]};
    check_blk("m59_b1", b, l, e, 1'b0);
    get_blk(0, b, l, lat);
    e = '0;
    e[448 +: 32] = 32'h000001D8;
    check_blk("m59_b2", b, l, e, 1'b1);

    // 64 bytes
    for (int i = 0; i < 16; i++)
      send(dw(i), 3'd4, i == 15);
    get_blk(0, b, l, lat);
    e = '0;
    for (int i = 0; i < 16; i++) e[32*i +: 32] = dw(i);
    check_blk("m64_b1", b, l, e, 1'b0);
    get_blk(0, b, l, lat);
    e = '0;
    e[31:0]      = 32'h00000080;
    e[448 +: 32] = 32'h00000200;
    check_blk("m64_b2", b, l, e, 1'b1);

    // in_bytes=7 clamps to 4
    send(32'h44332211, 3'd7, 1'b1);
    get_blk(0, b, l, lat);
    e = '0;
    e[31:0]      = 32'h44332211;
    e[63:32]     = 32'h00000080;
    e[448 +: 32] = 32'h00000020;
    check_blk("clamp", b, l, e, 1'b1);

    // reset mid-message, then "abc"
    for (int i = 0; i < 5; i++)
      send(dw(i), 3'd4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(blk_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_blk", 64'(blk == '0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    send(32'h00636261, 3'd3, 1'b1);
    get_blk(0, b, l, lat);
    e = '0;
    e[31:0]      = 32'h80636261;
    e[448 +: 32] = 32'h00000018;
    check_blk("post_rst_abc", b, l, e, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
